bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble converter: a WIDTH-bit unsigned binary value becomes five BCD digits (units through ten-thousands).
- Sits directly upstream of the BCD-to-7447 display stage and drives its BCDU/BCDT/BCDH/BCDTH/BCDTT inputs.
- Uses a start/busy/done handshake, one shift per clock.
- Also reports the count of significant digits so the display stage can blank leading zeros.

Parameters:
- WIDTH, 16, input binary width. Legal range 1..16, so the maximum value 65535 always fits in 5 digits. Values outside 1..16 are illegal; the implementation flags them with an elaboration-time error.

Ports:
- clock  input  1  rising-edge system clock.
- reset_n  input  1  reset, synchronous, active-low.
- start  input  1  conversion request, level-sampled on clock edges while idle.
- bin  input  WIDTH  unsigned binary value, sampled only on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digit outputs are valid.
- BCDU  output  4  units digit.
- BCDT  output  4  tens digit.
- BCDH  output  4  hundreds digit.
- BCDTH  output  4  thousands digit.
- BCDTT  output  4  ten-thousands digit.
- ndigits  output  3  number of significant digits, 1..5 (value 0 reports 1).

Behaviour:
Reset:
- reset_n low at a rising edge forces: state IDLE, busy=0, done=0, all digit outputs 4'd0, ndigits=3'd1, internal shift/scratch registers cleared.
- Reset has priority over every other event. Reset mid-conversion aborts it: no done pulse, outputs return to reset values.

States:
- IDLE: busy=0.
  - Transition: start=1 at an edge accepts the request. At that edge: bin is loaded into the binary shift register, the 20-bit BCD scratch is cleared, the shift counter is set to WIDTH, and the state goes to SHIFT.
  - Output: busy=1 from the next cycle.
- SHIFT: busy=1.
  - Each edge, every scratch nibble >= 5 gets +3 (all nibbles corrected in parallel from current values). Then {scratch, binary} shifts left by 1 and the counter decrements.
  - Transition: on the edge where the counter goes 1->0, go to IDLE.
  - Output, same edge: the final corrected-and-shifted scratch is registered into BCDU..BCDTT, ndigits is registered from the final scratch, done is set to 1, busy to 0.
- done is high for exactly one cycle, then returns to 0.

Latency and throughput:
- Acceptance at edge k gives done high and outputs valid in the cycle after edge k+WIDTH.
- With start held high, the next request is accepted at edge k+WIDTH+1, so back-to-back throughput is one conversion per WIDTH+1 cycles.

Boundary conditions:
- start while busy=1 is ignored; no queuing.
- Changes on bin after acceptance have no effect on the result in flight.
- Digit outputs and ndigits hold the last completed result until the next done; they never show intermediate scratch values.
- ndigits = index of the highest nonzero digit + 1. An all-zero result gives 1.
- Arithmetic: the +3 correction is 4-bit with no carry out. Nibbles never exceed 9 after a shift for legal WIDTH.

Test Plan:
- Zero: reset, then start with bin=0 -> done exactly 16 cycles after acceptance; all digits 0; ndigits=1; busy high for exactly 16 cycles.
- Maximum: bin=65535 -> BCDTT=6, BCDTH=5, BCDH=5, BCDT=3, BCDU=5; ndigits=5.
- Mid value: bin=1234 -> BCDTT=0, BCDTH=1, BCDH=2, BCDT=3, BCDU=4; ndigits=4.
- Start while busy: start bin=9, then pulse start with bin=777 at cycle 5 of the conversion -> single done, result 9 (BCDU=9, others 0, ndigits=1); no second done.
- Reset mid-conversion, then back-to-back: start bin=4321, drop reset_n for one cycle at shift 8 -> no done, outputs 0, ndigits=1. Then hold start high with bin=100 then bin=42 -> done pulses 17 cycles apart; results 100 (ndigits=3) then 42 (ndigits=2).
- WIDTH=8 instance: bin=255 -> BCDH=2, BCDT=5, BCDU=5, BCDTH=BCDTT=0; done 8 cycles after acceptance.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
//
// Signals:
//   start   - conversion request, sampled while the converter is idle
//   bin     - WIDTH-bit unsigned value, sampled on the accepting edge
//   busy    - high while a conversion is in progress
//   done    - one-cycle pulse when new digits are valid
//   BCDU..BCDTT - units through ten-thousands digits
//   ndigits - count of significant digits (1..5)
//
// Modports:
//   master - the requester (drives start/bin, observes results)
//   slave  - the converter
interface bin_to_bcd_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [3:0]       BCDU;
  logic [3:0]       BCDT;
  logic [3:0]       BCDH;
  logic [3:0]       BCDTH;
  logic [3:0]       BCDTT;
  logic [2:0]       ndigits;

  modport master (
    output start, bin,
    input  busy, done, BCDU, BCDT, BCDH, BCDTH, BCDTT, ndigits
  );

  modport slave (
    input  start, bin,
    output busy, done, BCDU, BCDT, BCDH, BCDTH, BCDTT, ndigits
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: a WIDTH-bit unsigned value becomes
// five BCD digits, one shift per clock, using a start/busy/done handshake.
// Also reports how many digits are significant so the display stage can
// blank leading zeros.
//
// Ports:
//   clock   - rising-edge system clock
//   reset_n - synchronous active-low reset
//   bus     - bin_to_bcd_seq_if slave: start/bin in; busy, done,
//             BCDU/BCDT/BCDH/BCDTH/BCDTT and ndigits out
module bin_to_bcd_seq #(
  parameter int WIDTH = 16
) (
  input logic             clock,
  input logic             reset_n,
  bin_to_bcd_seq_if.slave bus
);

  // WIDTH above 16 could overflow five digits; reject it at elaboration.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be in 1..16");
  end

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] bin_reg;
  logic [19:0]      scratch;
  logic [4:0]       count;

  logic [19:0] corrected;
  logic [19:0] shifted;
  logic [2:0]  shifted_ndigits;

  logic [19:0] result_reg;
  logic [2:0]  ndigits_reg;
  logic        done_reg;

  logic busy_int;
  logic accept;
  logic finish;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (count == 5'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_int = (state == SHIFT);
    accept   = (state == IDLE) && bus.start;
    finish   = (state == SHIFT) && (count == 5'd1);
  end

  // All five nibbles are corrected from their current values before the
  // shift; the 4-bit add never carries for legal WIDTH.
  always_comb begin
    corrected = scratch;
    for (int i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    shifted = {corrected[18:0], bin_reg[WIDTH-1]};
  end

  // Highest nonzero digit index plus one; an all-zero value still shows one digit.
  always_comb begin
    shifted_ndigits = 3'd1;
    if (shifted[19:16] != 4'd0) begin
      shifted_ndigits = 3'd5;
    end else if (shifted[15:12] != 4'd0) begin
      shifted_ndigits = 3'd4;
    end else if (shifted[11:8] != 4'd0) begin
      shifted_ndigits = 3'd3;
    end else if (shifted[7:4] != 4'd0) begin
      shifted_ndigits = 3'd2;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bin_reg     <= '0;
      scratch     <= '0;
      count       <= '0;
      result_reg  <= '0;
      ndigits_reg <= 3'd1;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        bin_reg <= bus.bin;
        scratch <= '0;
        count   <= 5'(WIDTH);
      end else if (busy_int) begin
        bin_reg <= bin_reg << 1;
        scratch <= shifted;
        count   <= count - 5'd1;
        // Outputs only ever see the finished value, never partial scratch.
        if (finish) begin
          result_reg  <= shifted;
          ndigits_reg <= shifted_ndigits;
          done_reg    <= 1'b1;
        end
      end
    end
  end

  assign bus.busy    = busy_int;
  assign bus.done    = done_reg;
  assign bus.BCDU    = result_reg[3:0];
  assign bus.BCDT    = result_reg[7:4];
  assign bus.BCDH    = result_reg[11:8];
  assign bus.BCDTH   = result_reg[15:12];
  assign bus.BCDTT   = result_reg[19:16];
  assign bus.ndigits = ndigits_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq: a 16-bit instance exercises the
// main function, handshake corner cases and reset; an 8-bit instance
// checks the narrow-width latency and result.
module tb_bin_to_bcd_seq;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  int check_count = 0;
  int pass_count  = 0;

  bin_to_bcd_seq_if #(.WIDTH(16)) bus16 ();
  bin_to_bcd_seq_if #(.WIDTH(8))  bus8 ();

  bin_to_bcd_seq #(.WIDTH(16)) dut16 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus16.slave)
  );

  bin_to_bcd_seq #(.WIDTH(8)) dut8 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus8.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [19:0] digits16();
    return {bus16.BCDTT, bus16.BCDTH, bus16.BCDH, bus16.BCDT, bus16.BCDU};
  endfunction

  function automatic logic [19:0] digits8();
    return {bus8.BCDTT, bus8.BCDTH, bus8.BCDH, bus8.BCDT, bus8.BCDU};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Raise start with a value at a falling edge, let the next rising edge
  // accept it, and drop start at the following falling edge.
  task automatic applyStimulus(input logic [15:0] value);
    bus16.start = 1'b1;
    bus16.bin   = value;
    @(negedge clock);
    bus16.start = 1'b0;
  endtask

  // Wait (bounded) for done on the 16-bit instance, counting cycles and busy samples.
  task automatic waitDone(input string tag, input int limit, output int cycles,
                          output int busy_cycles);
    bit seen;
    seen        = 1'b0;
    cycles      = 0;
    busy_cycles = bus16.busy ? 1 : 0;
    while (!seen && cycles < limit) begin
      @(negedge clock);
      cycles++;
      if (bus16.busy) busy_cycles++;
      if (bus16.done) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic countDones(input int window, output int dones);
    dones = 0;
    for (int i = 0; i < window; i++) begin
      @(negedge clock);
      if (bus16.done) dones++;
    end
  endtask

  initial begin
    int cycles;
    int busy_cycles;
    int dones;
    int lat8;

    bus16.start = 1'b0;
    bus16.bin   = '0;
    bus8.start  = 1'b0;
    bus8.bin    = '0;

    repeat (3) @(negedge clock);
    checkOutput("reset_busy", 32'(bus16.busy), 32'd0);
    checkOutput("reset_done", 32'(bus16.done), 32'd0);
    checkOutput("reset_digits", 32'(digits16()), 32'h00000);
    checkOutput("reset_ndigits", 32'(bus16.ndigits), 32'd1);
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] zero");
    applyStimulus(16'd0);
    waitDone("zero", 40, cycles, busy_cycles);
    checkOutput("zero_latency", 32'(cycles), 32'd16);
    checkOutput("zero_busy_cycles", 32'(busy_cycles), 32'd16);
    checkOutput("zero_digits", 32'(digits16()), 32'h00000);
    checkOutput("zero_ndigits", 32'(bus16.ndigits), 32'd1);
    @(negedge clock);
    checkOutput("zero_done_width", 32'(bus16.done), 32'd0);

    $display("[TB] maximum");
    applyStimulus(16'd65535);
    waitDone("max", 40, cycles, busy_cycles);
    checkOutput("max_digits", 32'(digits16()), 32'h65535);
    checkOutput("max_ndigits", 32'(bus16.ndigits), 32'd5);
    @(negedge clock);

    $display("[TB] mid value");
    applyStimulus(16'd1234);
    // bin changes after acceptance must not disturb the result in flight.
    bus16.bin = 16'd9999;
    waitDone("mid", 40, cycles, busy_cycles);
    checkOutput("mid_latency", 32'(cycles), 32'd16);
    checkOutput("mid_digits", 32'(digits16()), 32'h01234);
    checkOutput("mid_ndigits", 32'(bus16.ndigits), 32'd4);
    @(negedge clock);

    $display("[TB] start while busy");
    applyStimulus(16'd9);
    repeat (4) @(negedge clock);
    applyStimulus(16'd777);
    waitDone("busy_start", 40, cycles, busy_cycles);
    checkOutput("busy_start_digits", 32'(digits16()), 32'h00009);
    checkOutput("busy_start_ndigits", 32'(bus16.ndigits), 32'd1);
    countDones(30, dones);
    checkOutput("busy_start_no_second_done", 32'(dones), 32'd0);

    $display("[TB] reset mid-conversion");
    applyStimulus(16'd4321);
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    checkOutput("abort_busy", 32'(bus16.busy), 32'd0);
    checkOutput("abort_digits", 32'(digits16()), 32'h00000);
    checkOutput("abort_ndigits", 32'(bus16.ndigits), 32'd1);
    countDones(25, dones);
    checkOutput("abort_no_done", 32'(dones), 32'd0);

    $display("[TB] back-to-back");
    bus16.start = 1'b1;
    bus16.bin   = 16'd100;
    @(negedge clock);
    bus16.bin   = 16'd42;
    waitDone("b2b_first", 40, cycles, busy_cycles);
    checkOutput("b2b_first_digits", 32'(digits16()), 32'h00100);
    checkOutput("b2b_first_ndigits", 32'(bus16.ndigits), 32'd3);
    waitDone("b2b_second", 40, cycles, busy_cycles);
    bus16.start = 1'b0;
    checkOutput("b2b_gap", 32'(cycles), 32'd17);
    checkOutput("b2b_second_digits", 32'(digits16()), 32'h00042);
    checkOutput("b2b_second_ndigits", 32'(bus16.ndigits), 32'd2);
    repeat (20) @(negedge clock);

    $display("[TB] width 8");
    bus8.start = 1'b1;
    bus8.bin   = 8'd255;
    @(negedge clock);
    bus8.start = 1'b0;
    lat8 = 0;
    while (!bus8.done && lat8 < 30) begin
      @(negedge clock);
      lat8++;
    end
    checkOutput("w8_latency", 32'(lat8), 32'd8);
    checkOutput("w8_digits", 32'(digits8()), 32'h00255);
    checkOutput("w8_ndigits", 32'(bus8.ndigits), 32'd3);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
